// File: rtl/addx_sequencer.sv
// rtl/addx_sequencer.sv - noop/addx instruction sequencer emitting one beat per CPU cycle
module addx_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_op,
    input  logic [7:0] in_imm,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_delta,
    output logic [7:0] out_x,
    output logic [7:0] out_cycle,
    output logic [31:0] strength,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        NOOP  = 2'd1,
        ADDX1 = 2'd2,
        ADDX2 = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CYCLE = 8'd240;

    state_t      state, state_n;
    logic [7:0]  imm_q;
    logic [7:0]  x_q;
    logic [7:0]  cycle_q;
    logic [31:0] strength_q;
    logic        done_q;

    logic        beat_acc;
    logic        xfer;
    logic        sample_cycle;
    logic [31:0] cyc_ext;
    logic [31:0] x_ext;
    logic [31:0] product;
    state_t      in_state;

    // Handshakes, beat contents and the signal-strength product for this cycle
    always_comb begin
        out_valid    = (state != EMPTY) && !done_q;
        out_delta    = (state == ADDX2) ? imm_q : 8'd0;
        out_x        = x_q;
        out_cycle    = cycle_q;
        strength     = strength_q;
        frame_done   = done_q;
        in_ready     = !done_q && ((state == EMPTY) ||
                       (out_ready && ((state == NOOP) || (state == ADDX2)) && (cycle_q != LAST_CYCLE)));
        beat_acc     = out_valid && out_ready;
        xfer         = in_valid && in_ready;
        in_state     = in_op ? ADDX1 : NOOP;
        sample_cycle = (cycle_q == 8'd20)  || (cycle_q == 8'd60)  || (cycle_q == 8'd100) ||
                       (cycle_q == 8'd140) || (cycle_q == 8'd180) || (cycle_q == 8'd220);
        cyc_ext      = {24'd0, cycle_q};
        x_ext        = {{24{x_q[7]}}, x_q};
        product      = cyc_ext * x_ext;
    end

    // Next-state: advance on beat acceptance, chain straight into a same-cycle transfer
    always_comb begin
        state_n = state;
        case (state)
            EMPTY: begin
                if (xfer) state_n = in_state;
            end
            NOOP, ADDX2: begin
                if (beat_acc) state_n = xfer ? in_state : EMPTY;
            end
            ADDX1: begin
                // An addx straddling the end of the frame loses its second beat
                if (beat_acc) state_n = (cycle_q == LAST_CYCLE) ? EMPTY : ADDX2;
            end
            default: state_n = EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_n;
    end

    // Operand latch, X/cycle/strength accumulation and sticky end-of-frame flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q      <= 8'd0;
            x_q        <= 8'd1;
            cycle_q    <= 8'd1;
            strength_q <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            if (xfer) imm_q <= in_imm;
            if (beat_acc) begin
                x_q     <= x_q + out_delta;
                cycle_q <= cycle_q + 8'd1;
                if (sample_cycle) strength_q <= strength_q + product;
                if (cycle_q == LAST_CYCLE) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addx_sequencer.sv
// tb/tb_addx_sequencer.sv - scoreboard bench for addx_sequencer
module tb_addx_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [7:0]  in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_delta;
    logic [7:0]  out_x;
    logic [7:0]  out_cycle;
    logic [31:0] strength;
    logic        frame_done;

    logic        ready_manual;
    logic        bp_en;
    logic        bp_rand;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        logic signed [7:0] x;
        logic signed [7:0] delta;
    } beat_t;

    beat_t exp_q[$];

    int                m_cyc;
    logic signed [7:0] m_x;
    logic              m_done;

    addx_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_delta  (out_delta),
        .out_x      (out_x),
        .out_cycle  (out_cycle),
        .strength   (strength),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign out_ready = bp_en ? bp_rand : ready_manual;

    always @(posedge clk) begin
        #1 bp_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_beat(input int c, input logic signed [7:0] x, input logic signed [7:0] d);
        beat_t b;
        b.cyc = c; b.x = x; b.delta = d;
        exp_q.push_back(b);
    endtask

    // Scoreboard: every accepted beat must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'sd1, 32'sd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_cycle", {24'd0, out_cycle}, e.cyc);
                check("beat_x", $signed(out_x), e.x);
                check("beat_delta", $signed(out_delta), e.delta);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        m_cyc = 1; m_x = 8'sd1; m_done = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_delta", $signed(out_delta), 0);
        check("rst_out_x", $signed(out_x), 1);
        check("rst_out_cycle", {24'd0, out_cycle}, 1);
        check("rst_strength", $signed(strength), 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic signed [7:0] imm);
        bit ok;
        in_valid = 1'b1; in_op = op; in_imm = imm;
        push_beat(m_cyc, m_x, 8'sd0);
        if (op == 1'b0 || m_cyc == 240) begin
            m_cyc += 1;
        end else begin
            push_beat(m_cyc + 1, m_x, imm);
            m_x = m_x + imm;
            m_cyc += 2;
        end
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) check("send_timeout", 32'sd1, 32'sd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = (exp_q.size() == 0);
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1;
        end
        if (!ok) check("drain_timeout", 32'sd1, 32'sd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [7:0] x0;
        int c0;
        ready_manual = 1'b1; bp_en = 1'b0; bp_rand = 1'b1;
        in_op = 1'b0; in_imm = 8'd0; in_valid = 1'b0;
        do_reset();

        // noop; addx 3; addx -5 back to back
        send(1'b0, 8'sd0);
        send(1'b1, 8'sd3);
        send(1'b1, -8'sd5);
        drain();
        check("seq_final_x", $signed(out_x), -1);
        check("seq_final_cycle", {24'd0, out_cycle}, 6);

        // addx 7 stalled in its second beat
        x0 = m_x; c0 = m_cyc;
        send(1'b1, 8'sd7);
        @(posedge clk);
        #1 ready_manual = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 1);
            check("stall_delta", $signed(out_delta), 7);
            check("stall_x", $signed(out_x), x0);
            check("stall_cycle", {24'd0, out_cycle}, c0 + 1);
            @(posedge clk);
        end
        #1 ready_manual = 1'b1;
        @(posedge clk);
        #1;
        check("stall_x_after", $signed(out_x), x0 + 8'sd7);
        drain();

        // random instruction mix under random backpressure
        do_reset();
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++)
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        drain();
        bp_en = 1'b0;
        check("rand_x", $signed(out_x), m_x);

        // addx 127 then noop wraps X
        do_reset();
        send(1'b1, 8'sd127);
        send(1'b0, 8'sd0);
        drain();
        check("wrap_x", $signed(out_x), -128);

        // reset while the addx is in its second beat
        do_reset();
        send(1'b1, 8'sd9);
        @(posedge clk);
        #1 ready_manual = 1'b0;
        check("midaddx_delta", $signed(out_delta), 9);
        do_reset();
        ready_manual = 1'b1;
        send(1'b0, 8'sd0);
        drain();
        check("post_rst_x", $signed(out_x), 1);

        // full frame of noops
        do_reset();
        for (int i = 0; i < 240; i++) send(1'b0, 8'sd0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("frame_strength", $signed(strength), 720);
        check("frame_done", {31'd0, frame_done}, 1);
        check("frame_in_ready", {31'd0, in_ready}, 0);
        check("frame_out_valid", {31'd0, out_valid}, 0);

        // addx straddling the frame end loses its second beat
        do_reset();
        for (int i = 0; i < 239; i++) send(1'b0, 8'sd0);
        send(1'b1, 8'sd5);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("tail_frame_done", {31'd0, frame_done}, 1);
        check("tail_out_valid", {31'd0, out_valid}, 0);
        check("tail_x", $signed(out_x), 1);
        check("tail_in_ready", {31'd0, in_ready}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addx_sequencer.md
ADDX_SEQUENCER -- requirements
Module: addx_sequencer

Interface
REQ-001 SHALL have input clk, 1 bit: system clock; all state updates on rising edge.
REQ-002 SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have input in_valid, 1 bit: instruction present on in_op/in_imm.
REQ-004 SHALL have output in_ready, 1 bit: sequencer accepts instruction this cycle.
REQ-005 SHALL have input in_op, 1 bit: 0 = noop, 1 = addx.
REQ-006 SHALL have input in_imm, 8 bits, signed: addx operand; ignored for noop.
REQ-007 SHALL have output out_valid, 1 bit: one CPU-cycle beat present on the out_* outputs.
REQ-008 SHALL have input out_ready, 1 bit: downstream pixel stage consumes beat.
REQ-009 SHALL have output out_delta, 8 bits, signed: amount added to X at end of this CPU cycle.
REQ-010 SHALL have output out_x, 8 bits, signed: X value during this CPU cycle.
REQ-011 SHALL have output out_cycle, 8 bits: 1-based CPU cycle number of this beat.
REQ-012 SHALL have output strength, 32 bits, signed: running signal-strength sum.
REQ-013 SHALL have output frame_done, 1 bit: sticky; 240 beats accepted.

Function
REQ-014 SHALL hold at most one instruction; states EMPTY, NOOP, ADDX1, ADDX2.
REQ-015 SHALL accept an instruction when in_valid && in_ready (transfer); noop -> NOOP, addx -> ADDX1, with in_imm latched.
REQ-016 SHALL drive out_valid = 1 in NOOP, ADDX1 and ADDX2, and 0 in EMPTY or when frame_done = 1.
REQ-017 SHALL emit out_delta = 0 in NOOP and ADDX1, and the latched imm in ADDX2.
REQ-018 SHALL advance on beat acceptance (out_valid && out_ready): ADDX1 -> ADDX2; NOOP or ADDX2 -> EMPTY, or directly to the next instruction's state if a transfer occurs the same cycle.
REQ-019 SHALL hold all out_* outputs stable while out_valid && !out_ready.
REQ-020 SHALL compute in_ready = !frame_done && (state == EMPTY || (out_ready && state in {NOOP, ADDX2} && out_cycle != 240)); back-to-back instructions give 1 beat per clock.
REQ-021 SHALL, on each accepted beat, update X <= X + out_delta (8-bit two's-complement wrap) and cycle <= cycle + 1.
REQ-022 SHALL, on an accepted beat with out_cycle in {20, 60, 100, 140, 180, 220}, add out_cycle * out_x (signed, sign-extended to 32 bits) to strength.
REQ-023 SHALL set frame_done on acceptance of the beat with out_cycle = 240; thereafter in_ready = 0, out_valid = 0, and X/cycle/strength are frozen until rst.
REQ-024 SHALL discard the second beat if an addx's first beat is cycle 240; X is not updated by that addx.
REQ-025 SHALL apply no latency beyond state: a beat is visible the cycle after its instruction transfers.

Reset
REQ-026 SHALL on rst force state = EMPTY, X = 1, cycle = 1, strength = 0, frame_done = 0, out_valid = 0, and out_delta = 0.
REQ-027 SHALL, on rst mid-addx, drop the held instruction with no partial X update; in_ready = 1 on the first cycle after rst deasserts.

Verification
REQ-028 SHALL cover: noop; addx 3; addx -5 with out_ready = 1 -> beats (cycle, x, delta) = (1,1,0), (2,1,0), (3,1,3), (4,4,0), (5,4,-5); X ends at -1.
REQ-029 SHALL cover: addx 7 with out_ready low for 5 clocks during ADDX2 -> out_delta = 7, out_x and out_cycle held constant; X updates only on the ready cycle.
REQ-030 SHALL cover: 240 noops -> strength = 720, frame_done = 1 after beat 240, and in_ready = 0 afterwards.
REQ-031 SHALL cover: 239 noops then addx 5 -> beat 240 has delta 0, frame_done = 1, no beat 241, and X remains 1.
REQ-032 SHALL cover: addx 127 then noop -> the noop beat has out_x = -128 (wrap).
REQ-033 SHALL cover: rst asserted while in ADDX2 -> outputs at reset values; a following noop yields a beat (1,1,0).
